// File: rtl/collision_monitor.sv
// Frame-based dino/obstacle collision detector: counts overlapping pixels in a
// column window over each frame and latches a crash when the count reaches THRESH.
module collision_monitor #(
  parameter int unsigned         COLOR_W     = 12,
  parameter int unsigned         N_OBS       = 3,
  parameter logic [COLOR_W-1:0]  TRANSPARENT = {COLOR_W{1'b1}},
  parameter int unsigned         WIN_LEFT    = 30,
  parameter int unsigned         WIN_RIGHT   = 93,
  parameter int unsigned         THRESH      = 4,
  parameter int unsigned         CNT_W       = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     rdn,
  input  logic [9:0]               col_addr,
  input  logic [8:0]               row_addr,
  input  logic [COLOR_W-1:0]       dino,
  input  logic [N_OBS*COLOR_W-1:0] obstacle,
  input  logic                     frame_end,
  output logic                     crash,
  output logic                     crash_pulse,
  output logic [N_OBS-1:0]         hit_mask,
  output logic [CNT_W-1:0]         overlap_count,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [9:0]       WIN_L_C  = 10'(WIN_LEFT);
  localparam logic [9:0]       WIN_R_C  = 10'(WIN_RIGHT);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CRASHED} state_t;

  state_t             state_q, state_d;
  logic [N_OBS-1:0]   ov_q, ov_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [N_OBS-1:0]   acc_mask_q, acc_mask_d;
  logic               crash_q, crash_d;
  logic               crash_pulse_q, crash_pulse_d;
  logic [N_OBS-1:0]   hit_mask_q, hit_mask_d;
  logic [CNT_W-1:0]   overlap_count_q, overlap_count_d;
  logic               busy_q, busy_d;

  logic               qualify;
  logic [CNT_W-1:0]   tot;

  // Row position does not affect detection.
  logic unused_row;
  assign unused_row = ^row_addr;

  // Stage 1: per-channel overlap of the current pixel, only captured while running.
  always_comb begin
    ov_d    = '0;
    qualify = !rdn && (col_addr >= WIN_L_C) && (col_addr <= WIN_R_C);
    if (state_q == ST_RUN && !clear && qualify && dino != TRANSPARENT) begin
      for (int unsigned i = 0; i < N_OBS; i++) begin
        ov_d[i] = obstacle[i*COLOR_W +: COLOR_W] != TRANSPARENT;
      end
    end
  end

  // Saturating accumulator value including the stage-1 pixel.
  always_comb begin
    tot = acc_q;
    if (|ov_q && acc_q != CNT_MAX) begin
      tot = acc_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    acc_mask_d      = acc_mask_q;
    crash_d         = crash_q;
    crash_pulse_d   = 1'b0;
    hit_mask_d      = hit_mask_q;
    overlap_count_d = overlap_count_q;

    if (clear) begin
      acc_d      = '0;
      acc_mask_d = '0;
      crash_d    = 1'b0;
      hit_mask_d = '0;
      if (state_q == ST_CRASHED) begin
        state_d = en ? ST_RUN : ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          acc_d      = '0;
          acc_mask_d = '0;
          if (en) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (frame_end) begin
            overlap_count_d = tot;
            acc_d           = '0;
            acc_mask_d      = '0;
            if (tot >= THRESH_C) begin
              crash_d       = 1'b1;
              crash_pulse_d = 1'b1;
              hit_mask_d    = acc_mask_q | ov_q;
              state_d       = ST_CRASHED;
            end else if (!en) begin
              state_d = ST_IDLE;
            end
          end else if (!en) begin
            acc_d      = '0;
            acc_mask_d = '0;
            state_d    = ST_IDLE;
          end else begin
            acc_d      = tot;
            acc_mask_d = acc_mask_q | ov_q;
          end
        end
        ST_CRASHED: begin
          state_d = ST_CRASHED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      ov_q            <= '0;
      acc_q           <= '0;
      acc_mask_q      <= '0;
      crash_q         <= 1'b0;
      crash_pulse_q   <= 1'b0;
      hit_mask_q      <= '0;
      overlap_count_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ov_q            <= ov_d;
      acc_q           <= acc_d;
      acc_mask_q      <= acc_mask_d;
      crash_q         <= crash_d;
      crash_pulse_q   <= crash_pulse_d;
      hit_mask_q      <= hit_mask_d;
      overlap_count_q <= overlap_count_d;
      busy_q          <= busy_d;
    end
  end

  assign crash         = crash_q;
  assign crash_pulse   = crash_pulse_q;
  assign hit_mask      = hit_mask_q;
  assign overlap_count = overlap_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Bench for collision_monitor: directed frames plus random pixels against a
// frame-level reference model; a second instance uses a 3-bit counter.
module tb_collision_monitor;

  localparam logic [11:0] TR = 12'hfff;

  logic        clk = 1'b0;
  logic        rstn, en, clear, rdn, frame_end;
  logic [9:0]  col_addr;
  logic [8:0]  row_addr;
  logic [11:0] dino;
  logic [35:0] obstacle;

  logic       crash_a, crash_pulse_a, busy_a;
  logic [2:0] hit_mask_a;
  logic [9:0] overlap_count_a;
  logic       crash_b, crash_pulse_b, busy_b;
  logic [2:0] hit_mask_b;
  logic [2:0] overlap_count_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame-level counters plus the one pixel still in flight.
  int       m_st;      // 0 idle, 1 run, 2 crashed
  int       m_acc;
  int       m_ocount;
  logic [2:0] m_amask, m_pend, m_hmask;
  logic     m_crash, m_pulse;

  collision_monitor u_dut_a (
    .clk(clk), .rstn(rstn), .en(en), .clear(clear), .rdn(rdn),
    .col_addr(col_addr), .row_addr(row_addr), .dino(dino), .obstacle(obstacle),
    .frame_end(frame_end), .crash(crash_a), .crash_pulse(crash_pulse_a),
    .hit_mask(hit_mask_a), .overlap_count(overlap_count_a), .busy(busy_a)
  );

  collision_monitor #(.CNT_W(3)) u_dut_b (
    .clk(clk), .rstn(rstn), .en(en), .clear(clear), .rdn(rdn),
    .col_addr(col_addr), .row_addr(row_addr), .dino(dino), .obstacle(obstacle),
    .frame_end(frame_end), .crash(crash_b), .crash_pulse(crash_pulse_b),
    .hit_mask(hit_mask_b), .overlap_count(overlap_count_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [2:0] pix_mask(input logic r, input logic [9:0] c,
                                          input logic [11:0] d, input logic [35:0] o);
    logic [2:0] m;
    logic [11:0] ch;
    m = '0;
    if (!r && c >= 10'd30 && c <= 10'd93 && d != TR) begin
      for (int i = 0; i < 3; i++) begin
        ch = o[i*12 +: 12];
        m[i] = (ch != TR);
      end
    end
    return m;
  endfunction

  task automatic model_reset();
    m_st = 0; m_acc = 0; m_ocount = 0;
    m_amask = '0; m_pend = '0; m_hmask = '0;
    m_crash = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] new_pend;
    int tot;
    new_pend = (m_st == 1 && !clear) ? pix_mask(rdn, col_addr, dino, obstacle) : 3'b000;
    m_pulse = 1'b0;
    if (clear) begin
      m_crash = 1'b0; m_hmask = '0; m_acc = 0; m_amask = '0;
      if (m_st == 2) m_st = en ? 1 : 0;
    end else if (m_st == 0) begin
      m_acc = 0; m_amask = '0;
      if (en) m_st = 1;
    end else if (m_st == 1) begin
      tot = m_acc + ((m_pend != 0) ? 1 : 0);
      if (frame_end) begin
        m_ocount = tot;
        if (tot >= 4) begin
          m_crash = 1'b1; m_pulse = 1'b1; m_hmask = m_amask | m_pend; m_st = 2;
        end else if (!en) begin
          m_st = 0;
        end
        m_acc = 0; m_amask = '0;
      end else if (!en) begin
        m_st = 0; m_acc = 0; m_amask = '0;
      end else begin
        m_acc = tot; m_amask = m_amask | m_pend;
      end
    end
    m_pend = new_pend;
  endtask

  task automatic check_all();
    check_eq("crash_a", 32'(crash_a), 32'(m_crash));
    check_eq("pulse_a", 32'(crash_pulse_a), 32'(m_pulse));
    check_eq("hit_a", 32'(hit_mask_a), 32'(m_hmask));
    check_eq("count_a", 32'(overlap_count_a), 32'(sat(m_ocount, 1023)));
    check_eq("busy_a", 32'(busy_a), 32'(m_st == 1));
    check_eq("crash_b", 32'(crash_b), 32'(m_crash));
    check_eq("pulse_b", 32'(crash_pulse_b), 32'(m_pulse));
    check_eq("hit_b", 32'(hit_mask_b), 32'(m_hmask));
    check_eq("count_b", 32'(overlap_count_b), 32'(sat(m_ocount, 7)));
    check_eq("busy_b", 32'(busy_b), 32'(m_st == 1));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    clear     = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic set_px(input int col, input logic rd, input logic [2:0] ch);
    col_addr = 10'(col);
    rdn      = rd;
    dino     = 12'h000;
    for (int i = 0; i < 3; i++) obstacle[i*12 +: 12] = ch[i] ? 12'h0f0 : TR;
  endtask

  task automatic px(input int col, input logic rd, input logic [2:0] ch, input int n);
    for (int k = 0; k < n; k++) begin
      set_px(col + k, rd, ch);
      step();
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      set_px(0, 1'b1, 3'b000);
      step();
    end
  endtask

  task automatic fend();
    set_px(0, 1'b1, 3'b000);
    frame_end = 1'b1;
    step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_eq("rst_crash", 32'(crash_a), 32'd0);
    check_eq("rst_pulse", 32'(crash_pulse_a), 32'd0);
    check_eq("rst_hit", 32'(hit_mask_a), 32'd0);
    check_eq("rst_count", 32'(overlap_count_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    en = 1'b0; clear = 1'b0; frame_end = 1'b0; row_addr = '0;
    set_px(0, 1'b1, 3'b000);
    do_reset();

    // 3 overlaps: counted, no crash
    en = 1'b1;
    step();
    px(40, 1'b0, 3'b001, 3);
    idle(2);
    fend();
    check_eq("t1_count", 32'(overlap_count_a), 32'd3);
    check_eq("t1_crash", 32'(crash_a), 32'd0);
    check_eq("t1_busy", 32'(busy_a), 32'd1);

    // 4 overlaps on obs1: crash, single-cycle pulse, outputs then frozen
    px(50, 1'b0, 3'b010, 4);
    fend();
    check_eq("t2_crash", 32'(crash_a), 32'd1);
    check_eq("t2_pulse", 32'(crash_pulse_a), 32'd1);
    check_eq("t2_hit", 32'(hit_mask_a), 32'd2);
    idle(1);
    check_eq("t2_pulse_low", 32'(crash_pulse_a), 32'd0);
    px(50, 1'b0, 3'b101, 5);
    fend();
    check_eq("t2_hold_count", 32'(overlap_count_a), 32'd4);
    check_eq("t2_hold_hit", 32'(hit_mask_a), 32'd2);

    // clear out of CRASHED with en=1
    set_px(0, 1'b1, 3'b000);
    clear = 1'b1;
    step();
    check_eq("t5_crash", 32'(crash_a), 32'd0);
    check_eq("t5_hit", 32'(hit_mask_a), 32'd0);
    check_eq("t5_busy", 32'(busy_a), 32'd1);

    // window edges and rdn gating
    px(29, 1'b0, 3'b001, 1);
    px(94, 1'b0, 3'b001, 1);
    px(50, 1'b1, 3'b001, 1);
    fend();
    check_eq("t3_out", 32'(overlap_count_a), 32'd0);
    px(30, 1'b0, 3'b100, 1);
    px(93, 1'b0, 3'b100, 1);
    fend();
    check_eq("t3_edges", 32'(overlap_count_a), 32'd2);

    // 4th pixel one cycle before frame_end counts
    px(60, 1'b0, 3'b001, 4);
    fend();
    check_eq("t4_crash", 32'(crash_a), 32'd1);
    check_eq("t4_count", 32'(overlap_count_a), 32'd4);
    set_px(0, 1'b1, 3'b000);
    clear = 1'b1;
    step();

    // 4th pixel in the frame_end cycle belongs to the next frame
    px(60, 1'b0, 3'b001, 3);
    set_px(63, 1'b0, 3'b001);
    frame_end = 1'b1;
    step();
    check_eq("t4b_count", 32'(overlap_count_a), 32'd3);
    check_eq("t4b_crash", 32'(crash_a), 32'd0);
    idle(1);
    fend();
    check_eq("t4b_next", 32'(overlap_count_a), 32'd1);

    // clear beats frame_end
    px(60, 1'b0, 3'b011, 5);
    idle(1);
    set_px(0, 1'b1, 3'b000);
    clear = 1'b1;
    frame_end = 1'b1;
    step();
    check_eq("t5b_crash", 32'(crash_a), 32'd0);
    check_eq("t5b_count", 32'(overlap_count_a), 32'd1);
    fend();
    check_eq("t5b_acc", 32'(overlap_count_a), 32'd0);

    // mid-frame async reset, then empty and saturating frames
    px(60, 1'b0, 3'b001, 2);
    idle(2);
    #3;
    do_reset();
    en = 1'b1;
    step();
    fend();
    check_eq("t6_zero", 32'(overlap_count_a), 32'd0);
    px(40, 1'b0, 3'b001, 10);
    fend();
    check_eq("t6_count_a", 32'(overlap_count_a), 32'd10);
    check_eq("t6_count_b", 32'(overlap_count_b), 32'd7);
    check_eq("t6_crash_b", 32'(crash_b), 32'd1);
    set_px(0, 1'b1, 3'b000);
    clear = 1'b1;
    step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom_range(0, 99) < 95);
      clear     = ($urandom_range(0, 99) < 2);
      frame_end = ($urandom_range(0, 99) < 4);
      rdn       = clear ? 1'b1 : ($urandom_range(0, 99) < 30);
      col_addr  = 10'($urandom_range(20, 103));
      row_addr  = 9'($urandom_range(0, 479));
      dino      = ($urandom_range(0, 1) == 0) ? TR : 12'($urandom_range(0, 12'hffe));
      for (int i = 0; i < 3; i++)
        obstacle[i*12 +: 12] = ($urandom_range(0, 99) < 60) ? TR : 12'($urandom_range(0, 12'hffe));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
